ub_write_packer: RTL and testbench
==================================

UB_WRITE_PACKER -- requirements
Module: ub_write_packer

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the number of packed write-beat entries buffered (power of two, at least 2).
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 The block SHALL have these ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start_in  input  1  single-cycle pulse that begins a transfer
- len_in  input  6  number of 16-bit elements in the transfer (0..63), sampled on start_in
- stream_data_in  input  16  element data
- stream_valid_in  input  1  element offered
- stream_ready_out  output  1  element accepted when valid and ready are both high
- ub_stall_in  input  1  when high, no write beat is issued
- ub_write_data_1_out  output  16  upper-address lane
- ub_write_data_2_out  output  16  lower-address lane
- ub_write_valid_1_out  output  1  lane 1 valid
- ub_write_valid_2_out  output  1  lane 2 valid
- ub_write_start_out  output  1  write beat present
- busy_out  output  1  transfer in progress
- done_out  output  1  single-cycle completion pulse

Function
REQ-004 The block SHALL implement states IDLE, COLLECT and DRAIN; busy_out SHALL be high in COLLECT and DRAIN.
REQ-005 In IDLE, start_in with len_in>0 SHALL load remaining=len_in and enter COLLECT on the next edge.
REQ-006 In IDLE, start_in with len_in=0 SHALL remain in IDLE, issue no write beat, and pulse done_out in the next cycle.
REQ-007 start_in SHALL be ignored while busy_out is high.
REQ-008 stream_ready_out SHALL be combinationally high only in COLLECT with remaining>0 and the FIFO not full.
REQ-009 Each accepted element SHALL decrement remaining by 1.
REQ-010 A first-of-pair element SHALL be held in a half register when remaining>1 at acceptance.
REQ-011 A second-of-pair element SHALL push the pair entry {lower=held element, upper=new element} into the FIFO on the accepting edge.
REQ-012 When the final element (remaining=1) is accepted with the half register empty, the block SHALL push a single entry holding that element.
REQ-013 When remaining reaches 0, the state SHALL become DRAIN.
REQ-014 Pop rule: in any cycle with the FIFO non-empty and ub_stall_in low, the head entry SHALL pop, and the outputs SHALL present it in the following cycle.
REQ-015 For a pair entry, outputs SHALL be data_2=lower, data_1=upper, valid_1=valid_2=1.
REQ-016 For a single entry, outputs SHALL be data_1=element, data_2=0, valid_1=1, valid_2=0.
REQ-017 In a cycle with no pop, all valids SHALL be 0, and data outputs SHALL be 0.
REQ-018 ub_write_start_out SHALL equal valid_1 OR valid_2; all write outputs SHALL be registered.
REQ-019 Push and pop in the same cycle SHALL be permitted and leave the FIFO count unchanged; there is no empty-FIFO bypass.
REQ-020 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-021 Latency: with no stall and an empty FIFO, a beat SHALL appear 2 cycles after the accept edge that completed its entry.
REQ-022 In DRAIN, when the FIFO is empty and the last beat has been driven, done_out SHALL pulse for one cycle in the cycle following the last beat, and the state SHALL return to IDLE in that same cycle.
REQ-023 ub_stall_in SHALL NOT affect acceptance except through the FIFO-full condition; no element is ever dropped or duplicated.

Reset
REQ-024 While rst is high, on each clk edge the block SHALL set state=IDLE, remaining=0, clear the half register and FIFO pointers, and drive all outputs to 0, including stream_ready_out, busy_out and done_out.
REQ-025 Reset mid-transfer SHALL abandon the transfer with no done_out pulse, and buffered data SHALL be discarded.

Verification
REQ-026 len=4, elements A,B,C,D back-to-back, no stall -> beat1 data_2=A, data_1=B, both valids=1; beat2 data_2=C, data_1=D; then done_out pulses once; exactly 2 beats.
REQ-027 len=3, elements A,B,C -> beat1 (A lower, B upper); beat2 data_1=C, valid_1=1, data_2=0, valid_2=0; done_out follows.
REQ-028 len=10, ub_stall_in high for 12 cycles with a constant valid stream -> 8 elements accepted (4 pair entries), stream_ready_out low until the stall is released; after release, 5 beats appear in order with no loss.
REQ-029 start_in with len=0 -> done_out high exactly the next cycle; busy_out and ub_write_start_out stay 0.
REQ-030 len=6, rst asserted after 3 accepts -> the next cycle has all outputs 0 and state IDLE; no done_out; a new start with len=2 then completes normally.
REQ-031 start_in pulsed again mid-transfer with a different len -> ignored; the original length completes.

Source files
------------

// File: rtl/ub_write_packer.sv
// rtl/ub_write_packer.sv - packs 16-bit stream elements into paired unified-buffer write beats
// A small FIFO decouples element acceptance from write-beat issue under ub_stall_in.
module ub_write_packer #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_in,
   input  logic [5:0]  len_in,
   input  logic [15:0] stream_data_in,
   input  logic        stream_valid_in,
   output logic        stream_ready_out,
   input  logic        ub_stall_in,
   output logic [15:0] ub_write_data_1_out,
   output logic [15:0] ub_write_data_2_out,
   output logic        ub_write_valid_1_out,
   output logic        ub_write_valid_2_out,
   output logic        ub_write_start_out,
   output logic        busy_out,
   output logic        done_out
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

   state_t         state;
   logic [5:0]     remaining;
   logic           half_valid;
   logic [15:0]    half_data;

   // Entry layout: {is_pair, upper, lower}; a single entry keeps its element in upper.
   logic [32:0]    mem [FIFO_DEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [CW-1:0]  count;

   logic           fifo_full;
   logic           fifo_empty;
   logic           accept;
   logic           push;
   logic           pop;
   logic [32:0]    push_entry;
   logic [32:0]    head;

   assign fifo_full        = (count == CW'(FIFO_DEPTH));
   assign fifo_empty       = (count == '0);
   assign stream_ready_out = !rst && (state == COLLECT) && (remaining != 6'd0) && !fifo_full;
   assign accept           = stream_valid_in && stream_ready_out;
   assign push             = accept && (half_valid || (remaining == 6'd1));
   assign pop              = !fifo_empty && !ub_stall_in;
   assign push_entry       = half_valid ? {1'b1, stream_data_in, half_data}
                                        : {1'b0, stream_data_in, 16'h0000};
   assign head             = mem[rd_ptr];
   assign busy_out         = (state != IDLE);
   assign ub_write_start_out = ub_write_valid_1_out || ub_write_valid_2_out;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_entry;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state                <= IDLE;
         remaining            <= 6'd0;
         half_valid           <= 1'b0;
         half_data            <= 16'h0000;
         wr_ptr               <= '0;
         rd_ptr               <= '0;
         count                <= '0;
         ub_write_data_1_out  <= 16'h0000;
         ub_write_data_2_out  <= 16'h0000;
         ub_write_valid_1_out <= 1'b0;
         ub_write_valid_2_out <= 1'b0;
         done_out             <= 1'b0;
      end else begin
         done_out <= 1'b0;

         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (push && !pop) begin
            count <= count + CW'(1);
         end else if (pop && !push) begin
            count <= count - CW'(1);
         end

         if (pop) begin
            ub_write_data_1_out  <= head[31:16];
            ub_write_data_2_out  <= head[15:0];
            ub_write_valid_1_out <= 1'b1;
            ub_write_valid_2_out <= head[32];
         end else begin
            ub_write_data_1_out  <= 16'h0000;
            ub_write_data_2_out  <= 16'h0000;
            ub_write_valid_1_out <= 1'b0;
            ub_write_valid_2_out <= 1'b0;
         end

         if (accept) begin
            remaining <= remaining - 6'd1;
            if (half_valid) begin
               half_valid <= 1'b0;
            end else if (remaining != 6'd1) begin
               half_valid <= 1'b1;
               half_data  <= stream_data_in;
            end
         end

         case (state)
            IDLE: begin
               if (start_in) begin
                  if (len_in != 6'd0) begin
                     remaining <= len_in;
                     state     <= COLLECT;
                  end else begin
                     done_out <= 1'b1;
                  end
               end
            end
            COLLECT: begin
               if (accept && (remaining == 6'd1)) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               // An empty FIFO here means the last beat is on the outputs this cycle.
               if (fifo_empty) begin
                  done_out <= 1'b1;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ub_write_packer.sv
// tb/tb_ub_write_packer.sv - randomized check of ub_write_packer against a beat-list reference model
module tb_ub_write_packer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_in;
   logic [5:0]  len_in;
   logic [15:0] stream_data_in;
   logic        stream_valid_in;
   logic        stream_ready_out;
   logic        ub_stall_in;
   logic [15:0] ub_write_data_1_out;
   logic [15:0] ub_write_data_2_out;
   logic        ub_write_valid_1_out;
   logic        ub_write_valid_2_out;
   logic        ub_write_start_out;
   logic        busy_out;
   logic        done_out;

   int total = 0;
   int bad   = 0;

   ub_write_packer #(.FIFO_DEPTH(4)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .start_in             (start_in),
      .len_in               (len_in),
      .stream_data_in       (stream_data_in),
      .stream_valid_in      (stream_valid_in),
      .stream_ready_out     (stream_ready_out),
      .ub_stall_in          (ub_stall_in),
      .ub_write_data_1_out  (ub_write_data_1_out),
      .ub_write_data_2_out  (ub_write_data_2_out),
      .ub_write_valid_1_out (ub_write_valid_1_out),
      .ub_write_valid_2_out (ub_write_valid_2_out),
      .ub_write_start_out   (ub_write_start_out),
      .busy_out             (busy_out),
      .done_out             (done_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] all_outs();
      return {48'h0, stream_ready_out, ub_write_start_out, busy_out, done_out,
              ub_write_valid_1_out, ub_write_valid_2_out, 10'h0} |
             {32'h0, ub_write_data_1_out, ub_write_data_2_out};
   endfunction

   // Reference: the element list becomes beats {v1,v2,data_1,data_2}, pairs first, odd tail last.
   task automatic run_transfer(input int len, input int stall_n, input int stall_pct,
                               input int gap_pct, input bit restart);
      logic [15:0] elem[$];
      logic [33:0] exp_beats[$];
      int idx = 0, nbeats = 0, ndone = 0, c = 0;
      int done_c = -1, last_beat_c = -1, entry0_c = -1, first_beat_c = -1;
      bit saw_busy = 0, finished = 0;
      for (int i = 0; i < len; i++) elem.push_back(16'($urandom));
      for (int i = 0; i + 1 < len; i += 2) exp_beats.push_back({2'b11, elem[i+1], elem[i]});
      if (len % 2 == 1) exp_beats.push_back({2'b10, elem[len-1], 16'h0000});

      start_in        = 1'b1;
      len_in          = 6'(len);
      stream_valid_in = (len > 0) && ($urandom_range(99) >= gap_pct);
      stream_data_in  = (len > 0) ? elem[0] : 16'h0;
      ub_stall_in     = (stall_n > 0) || ($urandom_range(99) < stall_pct);

      while (!finished) begin
         @(negedge clk);
         if (busy_out) saw_busy = 1;
         if (ub_write_start_out) begin
            if (first_beat_c < 0) first_beat_c = c;
            if (nbeats < exp_beats.size())
               check("beat", {30'h0, ub_write_valid_1_out, ub_write_valid_2_out,
                              ub_write_data_1_out, ub_write_data_2_out}, {30'h0, exp_beats[nbeats]});
            else
               check("extra_beat", 64'(nbeats), 64'(exp_beats.size()));
            nbeats++;
            last_beat_c = c;
         end else begin
            check("idle_outs", {30'h0, ub_write_valid_1_out, ub_write_valid_2_out,
                                ub_write_data_1_out, ub_write_data_2_out}, 64'h0);
         end
         if (done_out) begin
            ndone++;
            if (done_c < 0) done_c = c;
            check("busy_at_done", 64'(busy_out), 64'h0);
         end
         if (stream_valid_in && stream_ready_out) begin
            idx++;
            if (idx == ((len > 1) ? 2 : 1)) entry0_c = c;
         end
         if (stall_n > 0 && c == stall_n - 1) begin
            check("stall_accepts", 64'(idx), 64'd8);
            check("stall_ready", 64'(stream_ready_out), 64'h0);
         end
         if (done_c >= 0 && c >= done_c + 2) finished = 1;
         if (c > 600) begin
            check("timeout", 64'(c), 64'd600);
            finished = 1;
         end
         @(posedge clk);
         #1;
         c++;
         start_in = restart && (c == 4);
         len_in   = restart ? 6'(len ^ 5) : 6'(len);
         stream_valid_in = (idx < len) && ($urandom_range(99) >= gap_pct);
         stream_data_in  = (idx < len) ? elem[idx] : 16'h0;
         ub_stall_in     = (c < stall_n) || ($urandom_range(99) < stall_pct);
      end
      stream_valid_in = 1'b0;
      ub_stall_in     = 1'b0;

      check("accepted", 64'(idx), 64'(len));
      check("num_beats", 64'(nbeats), 64'(exp_beats.size()));
      check("num_done", 64'(ndone), 64'd1);
      if (len == 0) begin
         check("len0_done_cycle", 64'(done_c), 64'd1);
         check("len0_busy", 64'(saw_busy), 64'h0);
      end else begin
         check("done_after_last", 64'(done_c), 64'(last_beat_c + 1));
         if (stall_n == 0 && stall_pct == 0)
            check("latency", 64'(first_beat_c), 64'(entry0_c + 2));
      end
   endtask

   initial begin
      int n3;
      rst = 1'b1;
      start_in = 1'b0;
      len_in = 6'd0;
      stream_data_in = 16'h0;
      stream_valid_in = 1'b0;
      ub_stall_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outs", all_outs(), 64'h0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      run_transfer(4, 0, 0, 0, 0);
      run_transfer(3, 0, 0, 0, 0);
      run_transfer(0, 0, 0, 0, 0);
      run_transfer(1, 0, 0, 0, 0);
      run_transfer(10, 12, 0, 0, 0);
      run_transfer(12, 0, 0, 0, 1);
      run_transfer(63, 0, 30, 30, 0);

      // Abandon a len=6 transfer after three accepts.
      start_in = 1'b1;
      len_in = 6'd6;
      @(posedge clk);
      #1;
      start_in = 1'b0;
      n3 = 0;
      stream_valid_in = 1'b1;
      for (int k = 0; k < 20 && n3 < 3; k++) begin
         stream_data_in = 16'(16'h1000 + n3);
         @(negedge clk);
         if (stream_ready_out) n3++;
         @(posedge clk);
         #1;
      end
      stream_valid_in = 1'b0;
      check("pre_reset_accepts", 64'(n3), 64'd3);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("mid_reset_outs", all_outs(), 64'h0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("no_done_after_reset", {62'h0, done_out, ub_write_start_out}, 64'h0);
      end
      @(posedge clk);
      #1;
      run_transfer(2, 0, 0, 0, 0);

      for (int t = 0; t < 12; t++)
         run_transfer($urandom_range(63), 0, $urandom_range(60), $urandom_range(50), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
